// File: rtl/fpga_cfg_loader_if.sv
// Byte-stream valid/ready channel feeding the configuration loader.
interface fpga_cfg_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fpga_cfg_loader.sv
// Byte-serial bitstream loader for the 2x2 CLB fabric: shadow assembly, pad check, atomic commit.
// Optional CRC-8 trailer check enabled by defining CFG_CRC_EN.
module fpga_cfg_loader #(
  parameter int unsigned FRAME_BYTES = 109,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  fpga_cfg_loader_if.slave     stream,
  output logic [143:0]         LUT_in,
  output logic [239:0]         SB_in,
  output logic [419:0]         CB_in,
  output logic [35:0]          sel_direction_BLEout,
  output logic [17:0]          sel_direction,
  output logic [8:0]           BLE_dff_select,
  output logic [3:0]           IO_sel,
  output logic                 fabric_reset,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_error
);

  localparam int unsigned FRAME_W = FRAME_BYTES * 8;
  localparam int unsigned CNT_W   = $clog2(FRAME_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, LOAD, CHECK, COMMIT, DONE, ERROR
`ifdef CFG_CRC_EN
    , CRC
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shadow;
  logic [CNT_W-1:0]   cnt;
  logic               ready_st, s_ready_c, accept;
  logic               shift_en, cnt_clr, cnt_inc, commit_en, start_go, err_go;
  logic               in_crc;

`ifdef CFG_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  assign in_crc = (state == CRC);
`else
  assign in_crc = 1'b0;
`endif

  // cfg_start has priority over any byte offered in the same cycle
  assign ready_st       = (state == SYNC) || (state == LOAD) || in_crc;
  assign s_ready_c      = ready_st && !cfg_start;
  assign stream.s_ready = s_ready_c;
  assign accept         = stream.s_valid && s_ready_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    commit_en = 1'b0;
    start_go  = 1'b0;
    err_go    = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (cfg_start) begin
          state_nxt = SYNC;
          start_go  = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      SYNC: begin
        if (cfg_start) begin
          cnt_clr = 1'b1;
        end else if (accept) begin
          cnt_clr = 1'b1;
          if (stream.s_data == SYNC_BYTE) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = ERROR;
            err_go    = 1'b1;
          end
        end
      end
      LOAD: begin
        if (cfg_start) begin
          state_nxt = SYNC;
          cnt_clr   = 1'b1;
        end else if (accept) begin
          shift_en = 1'b1;
          if (cnt == LAST_IDX) begin
`ifdef CFG_CRC_EN
            state_nxt = CRC;
`else
            state_nxt = CHECK;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef CFG_CRC_EN
      CRC: begin
        if (cfg_start) begin
          state_nxt = SYNC;
          cnt_clr   = 1'b1;
        end else if (accept) begin
          if (stream.s_data == crc) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = ERROR;
            err_go    = 1'b1;
          end
        end
      end
`endif
      CHECK: begin
        if (cfg_start) begin
          state_nxt = SYNC;
          cnt_clr   = 1'b1;
        end else if (shadow[FRAME_W-1]) begin
          state_nxt = ERROR;
          err_go    = 1'b1;
        end else begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = DONE;
        commit_en = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow assembly and byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      cnt    <= '0;
    end else begin
      if (shift_en) shadow <= {shadow[FRAME_W-9:0], stream.s_data};
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef CFG_CRC_EN
  // Running CRC over payload bytes only
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         crc <= 8'h00;
    else if (cnt_clr)  crc <= 8'h00;
    else if (shift_en) crc <= crc8_byte(crc, stream.s_data);
  end
`endif

  // All configuration buses update together, only on a verified frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IO_sel               <= '0;
      BLE_dff_select       <= '0;
      sel_direction        <= '0;
      sel_direction_BLEout <= '0;
      LUT_in               <= '0;
      SB_in                <= '0;
      CB_in                <= '0;
    end else if (commit_en) begin
      IO_sel               <= shadow[870:867];
      BLE_dff_select       <= shadow[866:858];
      sel_direction        <= shadow[857:840];
      sel_direction_BLEout <= shadow[839:804];
      LUT_in               <= shadow[803:660];
      SB_in                <= shadow[659:420];
      CB_in                <= shadow[419:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fabric_reset <= 1'b1;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_error    <= 1'b0;
    end else if (start_go) begin
      fabric_reset <= 1'b1;
      cfg_busy     <= 1'b1;
      cfg_done     <= 1'b0;
      cfg_error    <= 1'b0;
    end else if (commit_en) begin
      fabric_reset <= 1'b0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b1;
    end else if (err_go) begin
      cfg_busy     <= 1'b0;
      cfg_error    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader; expected buses come from a frame-level model.
module tb_fpga_cfg_loader;
  logic clk = 1'b0;
  logic reset;
  logic cfg_start;
  logic [143:0] LUT_in;
  logic [239:0] SB_in;
  logic [419:0] CB_in;
  logic [35:0]  sel_direction_BLEout;
  logic [17:0]  sel_direction;
  logic [8:0]   BLE_dff_select;
  logic [3:0]   IO_sel;
  logic fabric_reset, cfg_busy, cfg_done, cfg_error;

  fpga_cfg_loader_if bus();

  fpga_cfg_loader dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .stream(bus),
    .LUT_in(LUT_in), .SB_in(SB_in), .CB_in(CB_in),
    .sel_direction_BLEout(sel_direction_BLEout), .sel_direction(sel_direction),
    .BLE_dff_select(BLE_dff_select), .IO_sel(IO_sel),
    .fabric_reset(fabric_reset), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [870:0] exp_cfg;
  wire  [870:0] dut_cfg = {IO_sel, BLE_dff_select, sel_direction, sel_direction_BLEout,
                           LUT_in, SB_in, CB_in};

  task automatic chk(input string tag, input logic [871:0] obs, input logic [871:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Offer one byte, optionally after a one-cycle valid gap; returns at the negedge after acceptance
  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.s_valid = 1'b0;
      @(negedge clk);
    end
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    #1;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("send_timeout", 872'(n), 872'(0));
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  function automatic logic [871:0] rand_frame(input bit pad);
    logic [871:0] fr;
    for (int i = 0; i < 109; i++) fr[i*8 +: 8] = 8'($urandom());
    fr[871] = pad;
    return fr;
  endfunction

`ifdef CFG_CRC_EN
  // CRC-8 poly 0x07 as bit-serial polynomial division over the payload stream
  function automatic logic [7:0] crc_of(input logic [871:0] fr);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 871; i >= 0; i--) begin
      fb = c[7] ^ fr[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  // Sync byte, payload MSB first, trailer if enabled; cfg_start is issued by the caller
  task automatic send_frame(input logic [871:0] fr, input bit gap, input logic [7:0] crc_xor);
    logic [871:0] f;
    f = fr;
    send(8'hA5, gap);
    for (int i = 0; i < 109; i++) send(f[871 - 8*i -: 8], gap);
`ifdef CFG_CRC_EN
    send(crc_of(fr) ^ crc_xor, gap);
`else
    if (crc_xor != 8'h00) chk("crc_xor_unused", 872'(crc_xor), 872'(0));
`endif
  endtask

  task automatic load_and_check(input logic [871:0] fr, input bit gap, input bit ok,
                                input logic [7:0] crc_xor);
    send_frame(fr, gap, crc_xor);
    if (ok) begin
      chk("rst_hold_check", 872'(fabric_reset), 872'(1));
      tick(1);
      chk("rst_hold_commit", 872'(fabric_reset), 872'(1));
      chk("cfg_before_commit", 872'(dut_cfg), 872'(exp_cfg));
      tick(1);
      exp_cfg = fr[870:0];
      chk("rst_fall", 872'(fabric_reset), 872'(0));
      chk("cfg_commit", 872'(dut_cfg), 872'(exp_cfg));
      chk("done_set", 872'({cfg_done, cfg_busy, cfg_error}), 872'(3'b100));
    end else begin
      tick(3);
      chk("err_flags", 872'({cfg_error, cfg_done, cfg_busy, fabric_reset}), 872'(4'b1001));
      chk("cfg_kept", 872'(dut_cfg), 872'(exp_cfg));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [871:0] fr;
    reset = 1'b1;
    cfg_start = 1'b0;
    bus.s_data = 8'h00;
    bus.s_valid = 1'b0;
    exp_cfg = '0;
    #1;
    chk("in_reset_cfg", 872'(dut_cfg), 872'(0));
    chk("in_reset_flags", 872'({fabric_reset, cfg_busy, cfg_done, cfg_error}), 872'(4'b1000));
    @(negedge clk);
    reset = 1'b0;
    tick(10);
    chk("idle_cfg", 872'(dut_cfg), 872'(0));
    chk("idle_flags", 872'({fabric_reset, cfg_busy, cfg_done, cfg_error}), 872'(4'b1000));
    chk("idle_ready", 872'(bus.s_ready), 872'(0));

    // Directed frame with the documented field values
    fr = {1'b0, 4'hF, 9'h003, 18'h00002, 36'h000000088, 144'hCC99, 240'h0, 420'h0};
    pulse_start();
    chk("busy_after_start", 872'({cfg_busy, fabric_reset}), 872'(2'b11));
    load_and_check(fr, 1'b0, 1'b1, 8'h00);
    chk("io_sel", 872'(IO_sel), 872'(4'hF));
    chk("ble_dff", 872'(BLE_dff_select), 872'(9'h003));
    chk("sel_dir", 872'(sel_direction), 872'(18'h00002));
    chk("sel_ble_out", 872'(sel_direction_BLEout), 872'(36'h000000088));
    chk("lut_in", 872'(LUT_in), 872'(144'hCC99));
    chk("sb_cb", 872'({SB_in, CB_in}), 872'(0));

    // Bytes offered in DONE are ignored
    bus.s_data = 8'h3C;
    bus.s_valid = 1'b1;
    #1;
    chk("done_ready", 872'(bus.s_ready), 872'(0));
    tick(3);
    bus.s_valid = 1'b0;
    chk("done_cfg_stable", 872'(dut_cfg), 872'(exp_cfg));

    // Bad sync byte
    pulse_start();
    send(8'h5A, 1'b0);
    chk("badsync_flags", 872'({cfg_error, cfg_done, cfg_busy, fabric_reset}), 872'(4'b1001));
    chk("badsync_cfg", 872'(dut_cfg), 872'(exp_cfg));
    bus.s_valid = 1'b1;
    #1;
    chk("error_ready", 872'(bus.s_ready), 872'(0));
    @(negedge clk);
    bus.s_valid = 1'b0;

    // Pad bit set: first payload byte has its MSB high
    pulse_start();
    chk("start_clears_err", 872'(cfg_error), 872'(0));
    fr = rand_frame(1'b1);
    fr[871:864] = 8'h80;
    load_and_check(fr, 1'b0, 1'b0, 8'h00);

    // Abort after 50 payload bytes, then a full frame with valid toggling
    pulse_start();
    fr = rand_frame(1'b0);
    send(8'hA5, 1'b0);
    for (int i = 0; i < 50; i++) send(8'($urandom()), 1'b0);
    bus.s_data = 8'hFF;
    bus.s_valid = 1'b1;
    cfg_start = 1'b1;
    #1;
    chk("abort_ready", 872'(bus.s_ready), 872'(0));
    @(negedge clk);
    cfg_start = 1'b0;
    bus.s_valid = 1'b0;
    chk("abort_busy", 872'({cfg_busy, fabric_reset, cfg_done}), 872'(3'b110));
    chk("abort_cfg_kept", 872'(dut_cfg), 872'(exp_cfg));
    tick(15);
    load_and_check(fr, 1'b1, 1'b1, 8'h00);

    // Random frames, random valid gaps
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      load_and_check(rand_frame(1'b0), 1'($urandom_range(0, 1)), 1'b1, 8'h00);
    end

`ifdef CFG_CRC_EN
    pulse_start();
    load_and_check(rand_frame(1'b0), 1'b0, 1'b0, 8'h01);
`endif

    // Asynchronous reset in the middle of a load
    pulse_start();
    send(8'hA5, 1'b0);
    for (int i = 0; i < 30; i++) send(8'($urandom()), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    exp_cfg = '0;
    chk("midload_reset_cfg", 872'(dut_cfg), 872'(0));
    chk("midload_reset_flags", 872'({fabric_reset, cfg_busy, cfg_done, cfg_error}), 872'(4'b1000));
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    pulse_start();
    load_and_check(rand_frame(1'b0), 1'b0, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Upstream configuration stage for the 2x2 CLB fabric (`fpga`).
- Accepts a byte-serial bitstream over a valid/ready handshake and assembles it in a shadow register.
- After the frame checks out, commits it atomically to the wide configuration buses: LUT_in, SB_in, CB_in, sel_direction_BLEout, sel_direction, BLE_dff_select, IO_sel.
- Holds the fabric in reset while a load is in progress.

Parameters:
- FRAME_BYTES, 109, payload bytes per frame (872 bits = 1 pad bit + 871 config bits).
- SYNC_BYTE, 8'hA5, required first byte of every frame.

Ports:
- clk  input  1  fabric clock
- reset  input  1  asynchronous, active-high reset
- cfg_start  input  1  one-cycle pulse; begins or restarts a load
- s_data  input  8  bitstream byte
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts a byte this cycle
- LUT_in  output  144  committed LUT configuration
- SB_in  output  240  committed switch-box configuration
- CB_in  output  420  committed connection-box configuration
- sel_direction_BLEout  output  36  committed CLB output direction select
- sel_direction  output  18  committed CLB input direction select
- BLE_dff_select  output  9  committed BLE flip-flop bypass select
- IO_sel  output  4  committed IO direction select
- fabric_reset  output  1  reset to the fabric
- cfg_busy  output  1  load in progress
- cfg_done  output  1  a valid configuration is committed
- cfg_error  output  1  last load failed

Behaviour:
- Reset (async, active-high):
  - All config outputs 0, shadow 0, byte counter 0, state IDLE.
  - fabric_reset=1, s_ready=0, cfg_busy=0, cfg_done=0, cfg_error=0.
- Frame layout:
  - FRAME[871:0] = {pad(1), IO_sel, BLE_dff_select, sel_direction, sel_direction_BLEout, LUT_in, SB_in, CB_in}.
  - Bytes arrive most-significant first; each accepted byte updates shadow <= {shadow[863:0], s_data}.
- Byte transfer occurs when s_valid && s_ready on a rising clk edge.
- States:
  - IDLE:
    - s_ready=0; config outputs hold their last value.
    - cfg_start -> SYNC. On that edge: fabric_reset=1, cfg_busy=1, cfg_done=0, cfg_error=0.
  - SYNC:
    - s_ready=1.
    - Accepted byte == SYNC_BYTE -> LOAD, counter=0.
    - Any other accepted byte -> ERROR.
  - LOAD:
    - s_ready=1; counter increments per accepted byte.
    - When byte FRAME_BYTES-1 is accepted -> CHECK (or CRC when CFG_CRC_EN is defined).
  - CHECK: one cycle. shadow[871] (pad) must be 0: 0 -> COMMIT, 1 -> ERROR. s_ready=0.
  - COMMIT:
    - One cycle: all config outputs load from shadow simultaneously.
    - Next state DONE.
  - DONE:
    - fabric_reset=0, cfg_busy=0, cfg_done=1, s_ready=0.
    - cfg_start -> SYNC.
  - ERROR:
    - Config outputs keep their previous committed values (never partially updated).
    - fabric_reset stays 1, cfg_error=1, cfg_busy=0, s_ready=0.
    - cfg_start -> SYNC.
- Latency:
  - fabric_reset deasserts 2 cycles after the edge that accepts the last payload byte (CHECK, COMMIT); 3 cycles with CFG_CRC_EN.
  - Config outputs are valid from the cycle fabric_reset falls.
- cfg_start in SYNC/LOAD/CHECK/CRC:
  - Aborts the load: counter cleared, state SYNC.
  - Any byte offered that cycle is not accepted (s_ready=0 that cycle).
  - Previous committed outputs are retained.
- Stall: s_valid low for any number of cycles holds the state and counter indefinitely.
- Bytes offered in IDLE/DONE/ERROR are ignored (s_ready=0).
- Reset mid-load: the asynchronous clear wins. Outputs go to 0 and fabric_reset=1 regardless of state.

Optional Feature:
- Macro: CFG_CRC_EN.
- Defined:
  - After the last payload byte, enter state CRC with s_ready=1 and accept one trailer byte.
  - Running CRC-8 (poly 0x07, init 0x00, MSB-first) is computed over the payload bytes only; the sync byte is excluded.
  - Trailer == CRC -> CHECK; mismatch -> ERROR.
- Undefined: no CRC state and no trailer byte; LOAD goes directly to CHECK.

Test Plan:
- Reset then idle 10 cycles -> all config outputs 0, fabric_reset=1, cfg_done=0, s_ready=0.
- Normal load:
  - Stimulus: cfg_start, 0xA5, then 109 bytes encoding IO_sel=4'b1111, BLE_dff_select=9'h003, sel_direction=18'h00002, sel_direction_BLEout=36'h000000088, LUT_in[15:0]=16'hCC99, others 0.
  - Response: exact bus values appear together; fabric_reset falls 2 cycles after the last byte; cfg_done=1.
- Bad sync: cfg_start, first byte 0x5A -> cfg_error=1; prior committed outputs unchanged; fabric_reset=1.
- Pad bit set: first payload byte 0x80 -> ERROR after CHECK; outputs unchanged.
- Abort and stall:
  - cfg_start after 50 payload bytes, then a full valid frame with s_valid toggling every other cycle.
  - Response: only the second frame is committed; the counter restarts at 0.
- CFG_CRC_EN defined:
  - Correct trailer -> commit.
  - Trailer XOR 0x01 -> cfg_error=1, no commit.
